bench_bist_ctrl: RTL and testbench

Self-test driver and response compactor for the combinational benchmark netlists. It generates pseudo-random input patterns with an LFSR and drives them into the benchmark's `in` bus. It folds the benchmark's `out` bus into a MISR signature and compares the final signature against a golden value. It sits on the opposite side of the benchmark from the trojan-detection harness, which compares signatures between golden and suspect netlists.

---
 rtl/bench_bist_pkg.sv | 25 ++
 rtl/bench_bist_ctrl_fold.sv | 23 ++
 rtl/bench_bist_ctrl.sv | 128 ++++++++++++
 tb/tb_bench_bist_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bench_bist_pkg.sv
// Shared types and step functions for the benchmark BIST controller.
package bench_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } bist_state_t;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam int          LFSR_W    = 32;

    // Taps 31, 21, 1, 0 give a maximal-length sequence for the pattern source.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Galois-style signature update with the folded response XORed in.
    function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] fold);
        return {m[30:0], 1'b0} ^ (m[31] ? MISR_POLY : 32'h0) ^ fold;
    endfunction

endpackage

// File: rtl/bench_bist_ctrl_fold.sv
// Folds an OUT_W-bit response into 32 bits by XORing zero-padded 32-bit slices.
module bench_resp_fold #(
    parameter int OUT_W = 123
) (
    input  logic [OUT_W-1:0] response_in,
    output logic [31:0]      fold
);

    localparam int NSL = (OUT_W + 31) / 32;

    logic [NSL*32-1:0] padded;

    // Pad to whole slices, then XOR all slices together.
    always_comb begin
        padded              = '0;
        padded[OUT_W-1:0]   = response_in;
        fold                = '0;
        for (int s = 0; s < NSL; s++) begin
            fold = fold ^ padded[s*32 +: 32];
        end
    end

endmodule

// File: rtl/bench_bist_ctrl.sv
// BIST driver/compactor for combinational benchmark netlists.
// Optional macro BENCH_BIST_RESP_REG_EN: registers response_in before the
// fold and adds a one-cycle FLUSH state to absorb the final response.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | presenting one pattern per cycle, MISR absorbing responses
// FLUSH | registered-response build only: absorb the last captured response
// CMP   | compare signature against golden_sig
// DONE  | result held until next start
module bench_bist_ctrl
    import bench_bist_pkg::*;
#(
    parameter int          IN_W        = 178,
    parameter int          OUT_W       = 123,
    parameter int          PATTERN_CNT = 1024,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      golden_sig,
    input  logic [OUT_W-1:0] response_in,
    output logic [IN_W-1:0]  pattern_out,
    output logic [31:0]      signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    // Wide enough for PATTERN_CNT up to 2^16.
    localparam logic [16:0] CNT_LAST = 17'(PATTERN_CNT - 1);

    bist_state_t       state;
    logic [LFSR_W-1:0] lfsr;
    logic [31:0]       misr;
    logic [16:0]       cnt;
    logic [OUT_W-1:0]  fold_src;
    logic [31:0]       fold;

`ifdef BENCH_BIST_RESP_REG_EN
    logic [OUT_W-1:0]  resp_q;
    assign fold_src = resp_q;
`else
    assign fold_src = response_in;
`endif

    bench_resp_fold #(.OUT_W(OUT_W)) u_fold (
        .response_in (fold_src),
        .fold        (fold)
    );

    assign signature = misr;

    // Each input bit repeats the LFSR every 32 bits; quiet outside a run.
    genvar gi;
    generate
        for (gi = 0; gi < IN_W; gi++) begin : g_pat
            assign pattern_out[gi] = busy & lfsr[gi % 32];
        end
    endgenerate

    // Sequencing FSM with counter, LFSR, MISR and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= SEED;
            misr   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
`ifdef BENCH_BIST_RESP_REG_EN
            resp_q <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr   <= SEED;
                        misr   <= '0;
                        cnt    <= '0;
                        done   <= 1'b0;
                        pass   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef BENCH_BIST_RESP_REG_EN
                        resp_q <= '0;
`endif
                    end
                end
                RUN: begin
                    misr <= misr_step(misr, fold);
                    cnt  <= cnt + 17'd1;
`ifdef BENCH_BIST_RESP_REG_EN
                    resp_q <= response_in;
                    if (cnt == CNT_LAST) begin
                        // hold the last pattern so its response stays stable through FLUSH
                        state <= FLUSH;
                    end else begin
                        lfsr <= lfsr_step(lfsr);
                    end
`else
                    lfsr <= lfsr_step(lfsr);
                    if (cnt == CNT_LAST) begin
                        state <= CMP;
                    end
`endif
                end
                FLUSH: begin
                    misr  <= misr_step(misr, fold);
                    state <= CMP;
                end
                CMP: begin
                    pass  <= (misr == golden_sig);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// Directed self-checking bench for bench_bist_ctrl (PATTERN_CNT=4, SEED=1).
module tb_bench_bist_ctrl;
    import bench_bist_pkg::*;

    localparam int IN_W  = 178;
    localparam int OUT_W = 123;
    localparam int PCNT  = 4;
`ifdef BENCH_BIST_RESP_REG_EN
    localparam int DONE_LAT = PCNT + 2;
`else
    localparam int DONE_LAT = PCNT + 1;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      golden_sig;
    logic [OUT_W-1:0] response_in;
    logic [IN_W-1:0]  pattern_out;
    logic [31:0]      signature;
    logic             busy;
    logic             done;
    logic             pass;

    int errors = 0;
    int checks = 0;

    bench_bist_ctrl #(
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .PATTERN_CNT (PCNT),
        .SEED        (32'h0000_0001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .golden_sig  (golden_sig),
        .response_in (response_in),
        .pattern_out (pattern_out),
        .signature   (signature),
        .busy        (busy),
        .done        (done),
        .pass        (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (pattern_out !== '0) begin errors++; $display("FAIL reset_pattern got=%h exp=0", pattern_out); end
        checks++; if (signature !== 32'h0) begin errors++; $display("FAIL reset_sig got=%h exp=0", signature); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    endtask

    // Full run; first_resp applies only during the first RUN cycle.
    // hold_start keeps start high throughout the run, including the CMP edge.
    task automatic do_run(input string name, input logic [OUT_W-1:0] first_resp,
                          input logic [31:0] gold, input logic [31:0] exp_sig,
                          input logic exp_pass, input logic hold_start);
        int edges;
        int busy_cycles;
        golden_sig  = gold;
        response_in = first_resp;
        start       = 1'b1;
        tick();
        start       = hold_start;
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
            response_in = '0;
        end
        start = 1'b0;
        checks++; if (edges !== DONE_LAT) begin errors++; $display("FAIL %s done_latency got=%0d exp=%0d", name, edges, DONE_LAT); end
        checks++; if (busy_cycles !== DONE_LAT) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cycles, DONE_LAT); end
        checks++; if (signature !== exp_sig) begin errors++; $display("FAIL %s signature got=%h exp=%h", name, signature, exp_sig); end
        checks++; if (pass !== exp_pass) begin errors++; $display("FAIL %s pass got=%b exp=%b", name, pass, exp_pass); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got=%b exp=0", name, busy); end
        checks++; if (pattern_out !== '0) begin errors++; $display("FAIL %s pattern_done got=%h exp=0", name, pattern_out); end
    endtask

    task automatic test_zero_response();
        do_run("zero", '0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_single_bit();
        logic [OUT_W-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        do_run("bit0_pass", v, 32'h8, 32'h8, 1'b1, 1'b0);
        do_run("bit0_fail", v, 32'h9, 32'h8, 1'b0, 1'b0);
    endtask

    task automatic test_fold();
        logic [OUT_W-1:0] v;
        v     = '0;
        v[32] = 1'b1;
        do_run("bit32_fold", v, 32'h8, 32'h8, 1'b1, 1'b0);
        v     = '0;
        v[96] = 1'b1;
        v[0]  = 1'b1;
        do_run("bit0_96_cancel", v, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        logic [OUT_W-1:0] v;
        v    = '0;
        v[0] = 1'b1;
        do_run("start_held", v, 32'h8, 32'h8, 1'b1, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL start_held done_kept got=%b exp=1", done); end
    endtask

    task automatic test_pattern_and_reset();
        int n;
        checks++; if (pattern_out !== '0) begin errors++; $display("FAIL pat_idle got=%h exp=0", pattern_out); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (pattern_out[31:0] !== 32'h1) begin errors++; $display("FAIL pat_first got=%h exp=1", pattern_out[31:0]); end
        checks++; if (pattern_out[32] !== 1'b1) begin errors++; $display("FAIL pat_first_b32 got=%b exp=1", pattern_out[32]); end
        checks++; if (pattern_out[177:160] !== 18'h1) begin errors++; $display("FAIL pat_first_top got=%h exp=1", pattern_out[177:160]); end
        tick();
        checks++; if (pattern_out[31:0] !== 32'h3) begin errors++; $display("FAIL pat_second got=%h exp=3", pattern_out[31:0]); end
        rst = 1'b1;
        #1;
        test_reset();
        #2;
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (pattern_out[31:0] !== 32'h1) begin errors++; $display("FAIL replay_first got=%h exp=1", pattern_out[31:0]); end
        tick();
        checks++; if (pattern_out[31:0] !== 32'h3) begin errors++; $display("FAIL replay_second got=%h exp=3", pattern_out[31:0]); end
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL replay_done got=%b exp=1", done); end
        checks++; if (pattern_out !== '0) begin errors++; $display("FAIL pat_done got=%h exp=0", pattern_out); end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        golden_sig  = '0;
        response_in = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_zero_response();
        test_single_bit();
        test_fold();
        test_start_ignored();
        tick();
        test_pattern_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
